cbus_rr_arbiter: RTL and testbench
==================================

# cbus_rr_arbiter

Round-robin arbiter that shares the single cache bus (`cbus`) between N cache-side masters (icache refill, dcache refill/writeback, uncached ports). It sits between the caches and the top-level `creq`/`cresp` port of the cache manager. A grant is held for the whole burst, from request to the last-beat handshake, and rotates fairly between masters.

## Interface
- `NUM_INPUTS`, default 2: number of requesting masters (≥2).
- `IDX_W`, default `$clog2(NUM_INPUTS)`: width of the grant index.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high reset.
- `ireqs`  in  `cbus_req_t [NUM_INPUTS-1:0]`: master requests (`valid, is_write, size, addr, strobe, data, len`).
- `iresps`  out  `cbus_resp_t [NUM_INPUTS-1:0]`: per-master responses (`ready, last, data`).
- `oreq`  out  `cbus_req_t`: request forwarded to memory.
- `oresp`  in  `cbus_resp_t`: memory response.
- `busy`  out  1: a transaction is in flight.
- `grant_idx`  out  `IDX_W`: index of the currently granted master. Valid only while `busy` is asserted.

## Operation
- FSM with two states: IDLE and BUSY.
- **IDLE**
  - `oreq` is all-zero and every `iresps[i]` is all-zero.
  - If any `ireqs[i].valid` is set, select a winner by round-robin.
  - The search starts at `(last_idx+1) mod NUM_INPUTS` and wraps upward.
  - Register the winner into `grant_idx`, update `last_idx` to the winner, and go to BUSY.
- **BUSY**
  - `oreq = ireqs[grant_idx]`, driven combinationally from the live master request.
  - `iresps[grant_idx] = oresp`. All other `iresps` are all-zero.
  - Transaction ends when `oresp.ready && oresp.last` is high: go to IDLE.
  - Abort: if `ireqs[grant_idx].valid` is 0 in BUSY, go to IDLE and zero `oreq` in that cycle. The owning master's reset or flush is the cause.
- Non-granted masters must keep `valid` and payload stable. The arbiter never acknowledges them, because their `ready` is held at 0.
- `last_idx` persists across transactions and resets to `NUM_INPUTS-1`, so index 0 wins first after reset.
- Simultaneous requests are resolved purely by the round-robin order. No master has fixed priority.
- If the end of a burst and a new request from a different master land in the same cycle, the new request is arbitrated in the following IDLE cycle. No back-to-back grant in the cycle `last` is seen.
- Width rule: the index wraps mod `NUM_INPUTS`. A non-power-of-two `NUM_INPUTS` must never select an index ≥ `NUM_INPUTS`.

## Timing
- **Reset:** state = IDLE, `busy` = 0, `grant_idx` = 0, `last_idx` = `NUM_INPUTS-1`, `oreq` = 0, all `iresps` = 0.
- **Arbitration latency:** 1 cycle.
  - A request seen in IDLE at cycle t appears on `oreq` at cycle t+1.
- **Response path:** combinational. `iresps[grant_idx]` equals `oresp` in the same cycle.
- **Burst ownership:**
  - A burst of `len+1` beats holds the grant for all beats.
  - `busy` falls in the cycle after the `ready && last` handshake.
- **Minimum gap** between two transactions: 1 IDLE cycle.
- **Reset mid-burst:** state is forced to IDLE the next cycle regardless of `oresp`. The memory side must be reset by the same signal.
- `busy` equals (state == BUSY). `grant_idx` holds its value in IDLE.

## Test plan
1. **Reset check.** Assert `reset` for 2 cycles with both masters valid.
   - Required: `oreq.valid` = 0, `busy` = 0 and all `iresps` = 0 during reset.
   - Required: master 0 is granted at the first IDLE cycle, and `oreq` appears 1 cycle later.
2. **Single read burst.** Master 1 issues a read with `addr=0x1fc0_0000`, `len=3`. Memory returns 4 beats with `ready=1` and `last` on beat 4.
   - Required: `iresps[1]` mirrors all 4 beats and `iresps[0]` stays 0.
   - Required: `busy` drops 1 cycle after `last`.
3. **Contention and fairness.** Both masters hold `valid` continuously for 4 single-beat (`len=0`) transactions each.
   - Required: grants alternate 0,1,0,1,… with one IDLE cycle between them.
   - Required: no master waits longer than one other transaction.
4. **Hold under contention.** Master 0 starts a write with `len=7` and `strobe=0xf`. Master 1 raises `valid` at beat 2.
   - Required: `oreq` stays master 0's request through all 8 beats.
   - Required: master 1 is granted only after master 0's `last`.
5. **Abort.** Master 0 drops `valid` mid-burst at beat 2 of 4.
   - Required: the FSM returns to IDLE the next cycle with `oreq.valid` = 0.
   - Required: a pending master 1 is then granted.
6. **Reset mid-burst.** Assert `reset` at beat 3 of a `len=7` burst.
   - Required: all outputs are 0 on the next cycle.
   - Required: after reset, master 0 regains priority.

Source files
------------

// File: rtl/cbus_rr_arbiter.sv
// cbus_rr_arbiter: round-robin owner of the shared cache bus, holding each grant for a whole burst
package cbus_pkg;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [7:0]  len;
  } cbus_req_t;
  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;
endpackage

module cbus_rr_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_INPUTS = 2,
  parameter int IDX_W      = $clog2(NUM_INPUTS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  cbus_req_t [NUM_INPUTS-1:0]  ireqs,
  output cbus_resp_t [NUM_INPUTS-1:0] iresps,
  output cbus_req_t                   oreq,
  input  cbus_resp_t                  oresp,
  output logic                        busy,
  output logic [IDX_W-1:0]            grant_idx
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t                  r_state, w_next;
  logic [IDX_W-1:0]        r_grant, r_last, w_win;
  logic [NUM_INPUTS-1:0]   w_valid;
  logic                    w_any;
  cbus_req_t               w_greq;

  function automatic logic [IDX_W-1:0] wrap(input int j);
    return IDX_W'(j >= NUM_INPUTS ? j - NUM_INPUTS : j);
  endfunction

  assign busy      = (r_state == BUSY);
  assign grant_idx = r_grant;
  assign w_greq    = ireqs[r_grant];
  assign w_any     = |w_valid;

  // pick the first valid master after the previous winner, scanning upward with wrap
  always_comb begin
    w_win = r_last;
    for (int i = 0; i < NUM_INPUTS; i++) w_valid[i] = ireqs[i].valid;
    for (int k = NUM_INPUTS; k >= 1; k--)
      if (w_valid[wrap(int'(r_last) + k)]) w_win = wrap(int'(r_last) + k);
  end

  // route the owner's request out and memory's response back; end on last beat or owner abort
  always_comb begin
    w_next = r_state;
    oreq   = cbus_req_t'('0);
    iresps = '0;
    if (r_state == IDLE) begin
      w_next = w_any ? BUSY : IDLE;
    end else begin
      oreq           = w_greq.valid ? w_greq : cbus_req_t'('0);
      iresps[r_grant] = oresp;
      w_next         = (!w_greq.valid || (oresp.ready && oresp.last)) ? IDLE : BUSY;
    end
  end

  // state, grant and round-robin pointer; the winner is latched only when leaving IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= IDX_W'(NUM_INPUTS - 1);
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_any) begin
        r_grant <= w_win;
        r_last  <= w_win;
      end
    end
  end
endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// tb_cbus_rr_arbiter: directed and random bursts against a transaction-rule reference model
module tb_cbus_rr_arbiter;
  import cbus_pkg::*;
  logic                 clk = 0;
  logic                 reset;
  cbus_req_t [1:0]      ireqs;
  cbus_resp_t [1:0]     iresps;
  cbus_req_t            oreq;
  cbus_resp_t           oresp;
  logic                 busy;
  logic [0:0]           grant_idx;

  cbus_rr_arbiter #(.NUM_INPUTS(2)) dut (
    .clk(clk), .reset(reset), .ireqs(ireqs), .iresps(iresps),
    .oreq(oreq), .oresp(oresp), .busy(busy), .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int mb = 0, mg = 0, ml = 1;
  int beats[2] = '{0, 0};
  int remaining[2] = '{0, 0};
  logic [7:0] lens[2] = '{8'd0, 8'd0};
  bit wr[2] = '{0, 0};
  bit rdy_force = 1, rnd_len = 0, pbusy = 0;
  int nbusy = 0;
  int gq[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int last);
    for (int k = 1; k <= 2; k++) if (ireqs[(last + k) % 2].valid) return (last + k) % 2;
    return -1;
  endfunction

  task automatic new_req(input int i);
    if (rnd_len) wr[i] = 1'($urandom % 2);
    ireqs[i].valid    = 1;
    ireqs[i].is_write = wr[i];
    ireqs[i].size     = 3'($urandom % 3);
    ireqs[i].addr     = $urandom & 32'hffff_fffc;
    ireqs[i].strobe   = wr[i] ? 4'hf : 4'($urandom);
    ireqs[i].data     = $urandom;
    ireqs[i].len      = rnd_len ? 8'($urandom % 4) : lens[i];
  endtask

  task automatic tick();
    cbus_req_t eo;
    cbus_resp_t e0, e1;
    bit hs, fin;
    int g, w;
    if (mb != 0 && !reset) begin
      oresp.ready = rdy_force | 1'($urandom % 2);
      oresp.last  = oresp.ready && beats[mg] == int'(ireqs[mg].len);
    end else begin
      oresp.ready = 1'($urandom % 2);
      oresp.last  = 1'($urandom % 2);
    end
    oresp.data = $urandom;
    for (int i = 0; i < 2; i++)
      if (!reset && !ireqs[i].valid && remaining[i] > 0 && $urandom % 2 == 0) new_req(i);
    #1;
    eo = '0; e0 = '0; e1 = '0;
    if (mb != 0) begin
      eo = ireqs[mg].valid ? ireqs[mg] : '0;
      if (mg == 0) e0 = oresp; else e1 = oresp;
    end
    chk("busy", 128'(busy), 128'(mb != 0));
    if (mb != 0) chk("grant_idx", 128'(grant_idx), 128'(mg));
    chk("oreq", 128'(oreq), 128'(eo));
    chk("iresps0", 128'(iresps[0]), 128'(e0));
    chk("iresps1", 128'(iresps[1]), 128'(e1));
    if (busy && !pbusy) gq.push_back(int'(grant_idx));
    pbusy = busy;
    if (busy) nbusy++;
    @(posedge clk);
    g   = mg;
    hs  = !reset && mb != 0 && ireqs[mg].valid && oresp.ready;
    fin = hs && oresp.last;
    if (reset) begin
      mb = 0; mg = 0; ml = 1;
    end else if (mb == 0) begin
      w = pick(ml);
      if (w >= 0) begin mb = 1; mg = w; ml = w; end
    end else if (!ireqs[mg].valid || (oresp.ready && oresp.last)) mb = 0;
    @(negedge clk);
    if (reset) beats = '{0, 0};
    else if (fin) begin
      beats[g] = 0;
      remaining[g]--;
      ireqs[g].valid = 0;
      if (remaining[g] > 0) new_req(g);
    end else if (hs) beats[g]++;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((mb != 0 || ireqs[0].valid || ireqs[1].valid || remaining[0] > 0 || remaining[1] > 0) && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, 128'(n < budget), 128'(1));
  endtask

  task automatic wait_beats(input string tag, input int m, input int b);
    int n = 0;
    while (beats[m] < b && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_beats"}, 128'(n < 100), 128'(1));
  endtask

  task automatic chk_order(input string tag, input int exp[$]);
    chk({tag, "_count"}, 128'(gq.size()), 128'(exp.size()));
    for (int i = 0; i < exp.size() && i < gq.size(); i++) chk({tag, "_order"}, 128'(gq[i]), 128'(exp[i]));
  endtask

  initial begin
    ireqs = '0;
    oresp = '0;
    reset = 1;
    remaining = '{1, 1};
    new_req(0);
    new_req(1);
    @(posedge clk);
    @(negedge clk);
    tick();
    tick();
    reset = 0;
    gq.delete();
    tick();
    chk("first_grant", 128'(grant_idx), 128'(0));
    chk("first_oreq_valid", 128'(oreq.valid), 128'(1));
    wait_idle("reset", 100);
    chk_order("reset", '{0, 1});

    lens[1] = 8'd3; wr[1] = 0; remaining[1] = 1;
    new_req(1);
    ireqs[1].addr = 32'h1fc0_0000;
    nbusy = 0; gq.delete();
    wait_idle("read", 100);
    chk("read_busy_cycles", 128'(nbusy), 128'(4));
    chk_order("read", '{1});

    lens = '{8'd0, 8'd0}; remaining = '{4, 4};
    new_req(0);
    new_req(1);
    nbusy = 0; gq.delete();
    wait_idle("fair", 200);
    chk("fair_busy_cycles", 128'(nbusy), 128'(8));
    chk_order("fair", '{0, 1, 0, 1, 0, 1, 0, 1});

    wr[0] = 1; lens[0] = 8'd7; remaining[0] = 1;
    new_req(0);
    gq.delete();
    wait_beats("hold", 0, 2);
    wr[1] = 0; lens[1] = 8'd0; remaining[1] = 1;
    new_req(1);
    wait_idle("hold", 100);
    chk_order("hold", '{0, 1});

    wr[0] = 0; lens[0] = 8'd3; lens[1] = 8'd1; remaining = '{1, 1};
    new_req(0);
    new_req(1);
    gq.delete();
    wait_beats("abort", 0, 2);
    ireqs[0].valid = 0;
    remaining[0] = 0;
    tick();
    chk("abort_idle", 128'(busy), 128'(0));
    wait_idle("abort", 100);
    chk_order("abort", '{0, 1});

    lens[0] = 8'd7; lens[1] = 8'd0; remaining = '{1, 1};
    new_req(0);
    new_req(1);
    wait_beats("midrst", 0, 3);
    reset = 1;
    tick();
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_oreq", 128'(oreq), 128'(0));
    tick();
    reset = 0;
    gq.delete();
    tick();
    chk("midrst_regrant", 128'(grant_idx), 128'(0));
    wait_idle("midrst", 100);
    chk_order("midrst", '{0, 1});

    rnd_len = 1; rdy_force = 0; remaining = '{10, 10};
    wait_idle("random", 1500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
